// File: rtl/gray_ts_extender_pkg.sv
// Shared definitions for the Gray timestamp extender: lock-state encoding and
// error-counter sizing.
package gray_ts_extender_pkg;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

endpackage : gray_ts_extender_pkg

// File: rtl/gray_ts_extender_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray
// bits at and above its position.
module gray2bin #(
  parameter int N = 27
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  // Prefix-XOR decode from the MSB downwards.
  always_comb begin
    bin = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule : gray2bin

// File: rtl/gray_ts_extender.sv
// Synchronizes a free-running Gray counter, decodes it, judges each sampled
// step, extends it to EXT bits with a wrap counter and offers a one-deep
// capture buffer for triggered timestamps.
module gray_ts_extender
  import gray_ts_extender_pkg::*;
#(
  parameter int N        = 27,
  parameter int EXT      = 64,
  parameter int LOCK_CNT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic [N-1:0]     GRAY_IN,
  output logic [EXT-1:0]   TS_OUT,
  output logic             LOCKED,
  output logic [ERR_W-1:0] ERR_CNT,
  input  logic             TRIG,
  output logic [EXT-1:0]   CAP_TS,
  output logic             CAP_LOCKED,
  output logic             CAP_VALID,
  input  logic             CAP_READY,
  output logic             CAP_OVF
);

  localparam int HW = EXT - N;
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0] ONE_HW   = {{(HW-1){1'b0}}, 1'b1};

  logic [N-1:0]     g_s1_r, g_s2_r;
  logic [N-1:0]     bin_cur_s;
  logic [N-1:0]     lo_r;
  logic [HW-1:0]    hi_r;
  logic             first_r;
  lock_state_e      state_r, state_nxt_s;
  logic [3:0]       good_cnt_r, good_cnt_nxt_s, cnt_inc_s;
  logic [ERR_W-1:0] err_cnt_r, err_cnt_nxt_s;
  logic             locked_r;
  logic [N-1:0]     step_s;
  logic             good_s, wrap_s, load_s;
  logic [EXT-1:0]   cap_ts_r;
  logic             cap_locked_r, cap_valid_r, cap_ovf_r;

  gray2bin #(.N(N)) u_gray2bin (
    .gray (g_s2_r),
    .bin  (bin_cur_s)
  );

  // Step distance modulo 2^N; a hold or a +1 step is good.
  always_comb begin
    step_s = bin_cur_s - lo_r;
    good_s = (step_s == {N{1'b0}}) || (step_s == ONE_N);
    wrap_s = !first_r && (bin_cur_s < lo_r);
    load_s = TRIG && (!cap_valid_r || CAP_READY);
  end

  // Lock FSM next state, good-step counter and saturating error counter.
  always_comb begin
    state_nxt_s    = state_r;
    good_cnt_nxt_s = good_cnt_r;
    err_cnt_nxt_s  = err_cnt_r;
    cnt_inc_s      = good_cnt_r + 4'd1;
    if (!ENABLE) begin
      state_nxt_s    = ST_UNLOCKED;
      good_cnt_nxt_s = 4'd0;
    end else if (first_r) begin
      state_nxt_s    = state_r;
      good_cnt_nxt_s = good_cnt_r;
    end else begin
      case (state_r)
        ST_UNLOCKED: begin
          if (!good_s) begin
            good_cnt_nxt_s = 4'd0;
          end else if (cnt_inc_s == LOCK_TGT) begin
            state_nxt_s    = ST_LOCKED;
            good_cnt_nxt_s = 4'd0;
          end else begin
            good_cnt_nxt_s = cnt_inc_s;
          end
        end
        ST_LOCKED: begin
          if (!good_s) begin
            state_nxt_s    = ST_UNLOCKED;
            good_cnt_nxt_s = 4'd0;
            if (err_cnt_r != ERR_MAX) begin
              err_cnt_nxt_s = err_cnt_r + 8'd1;
            end else begin
              err_cnt_nxt_s = err_cnt_r;
            end
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        default: begin
          state_nxt_s    = ST_UNLOCKED;
          good_cnt_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // Two-flop synchronizer, timestamp extension and first-sample tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      g_s1_r  <= {N{1'b0}};
      g_s2_r  <= {N{1'b0}};
      lo_r    <= {N{1'b0}};
      hi_r    <= {HW{1'b0}};
      first_r <= 1'b1;
    end else begin
      g_s1_r  <= GRAY_IN;
      g_s2_r  <= g_s1_r;
      lo_r    <= bin_cur_s;
      first_r <= 1'b0;
      if (wrap_s) begin
        hi_r <= hi_r + ONE_HW;
      end
    end
  end

  // Lock state, counters and the registered LOCKED flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_UNLOCKED;
      good_cnt_r <= 4'd0;
      err_cnt_r  <= {ERR_W{1'b0}};
      locked_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      good_cnt_r <= good_cnt_nxt_s;
      err_cnt_r  <= err_cnt_nxt_s;
      locked_r   <= (state_nxt_s == ST_LOCKED);
    end
  end

  // One-deep capture buffer with a sticky overflow flag for dropped triggers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_ts_r     <= {EXT{1'b0}};
      cap_locked_r <= 1'b0;
      cap_valid_r  <= 1'b0;
      cap_ovf_r    <= 1'b0;
    end else begin
      if (load_s) begin
        cap_ts_r     <= {hi_r, lo_r};
        cap_locked_r <= locked_r;
        cap_valid_r  <= 1'b1;
      end else if (cap_valid_r && CAP_READY) begin
        cap_valid_r <= 1'b0;
      end
      if (TRIG && cap_valid_r && !CAP_READY) begin
        cap_ovf_r <= 1'b1;
      end
    end
  end

  assign TS_OUT     = {hi_r, lo_r};
  assign LOCKED     = locked_r;
  assign ERR_CNT    = err_cnt_r;
  assign CAP_TS     = cap_ts_r;
  assign CAP_LOCKED = cap_locked_r;
  assign CAP_VALID  = cap_valid_r;
  assign CAP_OVF    = cap_ovf_r;

endmodule : gray_ts_extender
